lv1_lv2_bus_arbiter: RTL and testbench
======================================

// Module: lv1_lv2_bus_arbiter
// PURPOSE
//  Arbitrates the shared lv1<->lv2 bus among the per-core lv1 caches.
//  - Grants one processor-side owner (bus_lv1_lv2_req_proc) at a time, round-robin.
//  - While an owner holds the bus, grants one snooping core (bus_lv1_lv2_req_snoop) for data/invalidation response.
//  - Sits directly downstream of each core's lv1 cache and consumes its req_proc/req_snoop outputs.
// PARAMETERS
//  NUM_CORES     4    number of lv1 requesters; one req/gnt bit per core
//  CORE_ID_WID   2    width of owner id, clog2(NUM_CORES)
//  HOLD_CNT_WID  8    width of grant-hold counter (timeout feature only)
//  MAX_HOLD      255  cycles a proc grant may be held before timeout flag (timeout feature only)
// PORTS
//  clk                    in   1              system clock, rising edge
//  rst                    in   1              asynchronous reset, active-high
//  bus_lv1_lv2_req_proc   in   NUM_CORES      per-core processor-side bus request
//  bus_lv1_lv2_req_snoop  in   NUM_CORES      per-core snoop-side bus request
//  bus_lv1_lv2_gnt_proc   out  NUM_CORES      one-hot processor-side grant
//  bus_lv1_lv2_gnt_snoop  out  NUM_CORES      one-hot snoop-side grant
//  gnt_proc_id            out  CORE_ID_WID    index of current proc owner; valid when bus_busy
//  bus_busy               out  1              any grant (proc or snoop) active
//  arb_timeout            out  1              sticky hold-timeout flag (tied 0 when feature off)
// BEHAVIOUR
//  - Reset: all grants 0; gnt_proc_id=0; bus_busy=0; arb_timeout=0; both RR pointers=0; state IDLE.
//  - All outputs registered; no combinational path from req to gnt.
//  - States: IDLE, PROC, PROC_SNOOP, SNOOP_DRAIN.
//  - IDLE:
//    - any req_proc at cycle N -> gnt_proc one-hot at N+1, state PROC.
//    - Winner is the first requester at or after proc_ptr, wrapping NUM_CORES-1 -> 0.
//    - req_snoop is ignored in IDLE.
//  - PROC:
//    - gnt_proc held while owner's req_proc stays high.
//    - Owner drops req at N -> gnt_proc=0 at N+1, state IDLE, proc_ptr=owner+1 (mod NUM_CORES).
//    - Earliest next proc grant is N+2: one turnaround cycle, even when the same core re-requests.
//    - A req_snoop from a core other than the owner at N -> gnt_snoop one-hot at N+1, state PROC_SNOOP.
//    - Snoop winner picked round-robin from snoop_ptr; the owner's own req_snoop bit is masked.
//    - Owner drop and snoop request in the same cycle: owner drop wins, state IDLE, no snoop grant.
//  - PROC_SNOOP:
//    - Both grants held.
//    - Snooper drops req at N -> gnt_snoop=0 at N+1, snoop_ptr=snooper+1, state PROC.
//      No new snoop grant in that same cycle.
//    - Owner drops req while snoop still held -> gnt_proc=0 next cycle, state SNOOP_DRAIN.
//    - Both drop in the same cycle -> both grants 0 next cycle, both pointers advance, state IDLE.
//  - SNOOP_DRAIN:
//    - gnt_snoop held until snooper drops -> IDLE next cycle.
//    - New req_proc waits until IDLE.
//  - Invariants:
//    - At most one bit set in each grant vector.
//    - gnt_snoop never equals gnt_proc.
//    - gnt_snoop is never set without an owner except in SNOOP_DRAIN.
//  - bus_busy = |gnt_proc | |gnt_snoop, registered alongside the grants.
//  - gnt_proc_id holds its last value in IDLE.
//  - Reset asserted mid-transaction clears all grants immediately (async).
//    First grant after reset deassertion goes to the lowest-index requester.
// CONFIGURATION
//  - LV1_LV2_ARB_TIMEOUT_EN defined:
//    - HOLD_CNT_WID counter counts cycles with gnt_proc asserted for the same owner.
//    - Counter clears on every new proc grant.
//    - When the count reaches MAX_HOLD, arb_timeout sets and stays set until rst.
//    - Grants are not revoked.
//    - Counter saturates, no wrap.
//  - LV1_LV2_ARB_TIMEOUT_EN undefined: no counter; arb_timeout tied 0.
// TESTING
//  1. rst, then req_proc=4'b1010 -> next cycle gnt_proc=4'b0010, gnt_proc_id=1, bus_busy=1.
//  2. Core1 drops req with 4'b1010 still pending -> gnt 0 for one cycle, then gnt_proc=4'b1000 (id 3).
//     Repeat the sequence; the next winner is core1 (wrap).
//  3. Owner core0; req_snoop=4'b0111 -> gnt_snoop=4'b0010 (own bit masked).
//     Core1 snoop drops -> gnt_snoop=0 for one cycle, then 4'b0100.
//  4. Owner core2 with snoop core3 granted; core2 drops req_proc -> gnt_proc=0, gnt_snoop=4'b1000 held.
//     Core3 drops req -> IDLE, bus_busy=0.
//  5. Assert rst while in PROC_SNOOP -> all grants 0 the same cycle.
//     After release, req_proc=4'b1111 -> gnt_proc=4'b0001.
//  6. With LV1_LV2_ARB_TIMEOUT_EN and MAX_HOLD=8: hold core0 req_proc 12 cycles -> arb_timeout=1 after 8 granted cycles.
//     Flag stays 1 after release and clears only on rst.

Source files
------------

// File: rtl/lv1_lv2_bus_arbiter.sv
// lv1<->lv2 shared bus arbiter: round-robin processor-side owner plus one
// round-robin snoop responder while an owner holds the bus.
// Optional feature macro: LV1_LV2_ARB_TIMEOUT_EN (sticky grant-hold timeout flag).
module lv1_lv2_bus_arbiter #(
    parameter int unsigned NUM_CORES    = 4,
    parameter int unsigned CORE_ID_WID  = 2,
    parameter int unsigned HOLD_CNT_WID = 8,
    parameter int unsigned MAX_HOLD     = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CORES-1:0]   bus_lv1_lv2_req_proc,
    input  logic [NUM_CORES-1:0]   bus_lv1_lv2_req_snoop,
    output logic [NUM_CORES-1:0]   bus_lv1_lv2_gnt_proc,
    output logic [NUM_CORES-1:0]   bus_lv1_lv2_gnt_snoop,
    output logic [CORE_ID_WID-1:0] gnt_proc_id,
    output logic                   bus_busy,
    output logic                   arb_timeout
);

    typedef enum logic [1:0] {IDLE, PROC, PROC_SNOOP, SNOOP_DRAIN} state_t;

    // Reject configurations the id and hold counter cannot represent.
    if (NUM_CORES > (1 << CORE_ID_WID)) begin : g_bad_id_wid
        $error("CORE_ID_WID too narrow for NUM_CORES");
    end
    if (MAX_HOLD >= (1 << HOLD_CNT_WID)) begin : g_bad_max_hold
        $error("MAX_HOLD exceeds hold counter range");
    end

    state_t                 state, state_n;
    logic [NUM_CORES-1:0]   gnt_proc_n, gnt_snoop_n;
    logic [CORE_ID_WID-1:0] proc_id_n;
    logic [CORE_ID_WID-1:0] snoop_id, snoop_id_n;
    logic [CORE_ID_WID-1:0] proc_ptr, proc_ptr_n;
    logic [CORE_ID_WID-1:0] snoop_ptr, snoop_ptr_n;
    logic                   bus_busy_n;
    logic                   owner_drop, snoop_drop;
    logic [NUM_CORES-1:0]   snoop_cand;

    // First set bit of req at or after ptr, wrapping to 0.
    function automatic logic [CORE_ID_WID-1:0] rr_pick(input logic [NUM_CORES-1:0]   req,
                                                       input logic [CORE_ID_WID-1:0] ptr);
        logic [CORE_ID_WID-1:0] pick;
        logic                   found;
        int unsigned            idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (!found && req[CORE_ID_WID'(idx)]) begin
                pick  = CORE_ID_WID'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Successor id modulo NUM_CORES.
    function automatic logic [CORE_ID_WID-1:0] next_id(input logic [CORE_ID_WID-1:0] id);
        if (id == CORE_ID_WID'(NUM_CORES - 1)) return '0;
        return id + CORE_ID_WID'(1);
    endfunction

    function automatic logic [NUM_CORES-1:0] onehot(input logic [CORE_ID_WID-1:0] id);
        logic [NUM_CORES-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Request qualifiers for the current owner and snooper.
    always_comb begin
        owner_drop = !bus_lv1_lv2_req_proc[gnt_proc_id];
        snoop_drop = !bus_lv1_lv2_req_snoop[snoop_id];
        snoop_cand = bus_lv1_lv2_req_snoop & ~bus_lv1_lv2_gnt_proc;
    end

    // Next-state and next-grant decode.
    always_comb begin
        state_n     = state;
        gnt_proc_n  = bus_lv1_lv2_gnt_proc;
        gnt_snoop_n = bus_lv1_lv2_gnt_snoop;
        proc_id_n   = gnt_proc_id;
        snoop_id_n  = snoop_id;
        proc_ptr_n  = proc_ptr;
        snoop_ptr_n = snoop_ptr;
        case (state)
            IDLE: begin
                if (|bus_lv1_lv2_req_proc) begin
                    proc_id_n  = rr_pick(bus_lv1_lv2_req_proc, proc_ptr);
                    gnt_proc_n = onehot(proc_id_n);
                    state_n    = PROC;
                end
            end
            PROC: begin
                if (owner_drop) begin
                    gnt_proc_n = '0;
                    proc_ptr_n = next_id(gnt_proc_id);
                    state_n    = IDLE;
                end else if (|snoop_cand) begin
                    snoop_id_n  = rr_pick(snoop_cand, snoop_ptr);
                    gnt_snoop_n = onehot(snoop_id_n);
                    state_n     = PROC_SNOOP;
                end
            end
            PROC_SNOOP: begin
                if (owner_drop) begin
                    gnt_proc_n = '0;
                    proc_ptr_n = next_id(gnt_proc_id);
                end
                if (snoop_drop) begin
                    gnt_snoop_n = '0;
                    snoop_ptr_n = next_id(snoop_id);
                end
                if (owner_drop && snoop_drop) state_n = IDLE;
                else if (owner_drop)          state_n = SNOOP_DRAIN;
                else if (snoop_drop)          state_n = PROC;
            end
            SNOOP_DRAIN: begin
                if (snoop_drop) begin
                    gnt_snoop_n = '0;
                    snoop_ptr_n = next_id(snoop_id);
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        bus_busy_n = (|gnt_proc_n) | (|gnt_snoop_n);
    end

    // State, grant and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= IDLE;
            bus_lv1_lv2_gnt_proc  <= '0;
            bus_lv1_lv2_gnt_snoop <= '0;
            gnt_proc_id           <= '0;
            snoop_id              <= '0;
            proc_ptr              <= '0;
            snoop_ptr             <= '0;
            bus_busy              <= 1'b0;
        end else begin
            state                 <= state_n;
            bus_lv1_lv2_gnt_proc  <= gnt_proc_n;
            bus_lv1_lv2_gnt_snoop <= gnt_snoop_n;
            gnt_proc_id           <= proc_id_n;
            snoop_id              <= snoop_id_n;
            proc_ptr              <= proc_ptr_n;
            snoop_ptr             <= snoop_ptr_n;
            bus_busy              <= bus_busy_n;
        end
    end

`ifdef LV1_LV2_ARB_TIMEOUT_EN
    logic [HOLD_CNT_WID-1:0] hold_cnt, hold_cnt_n;
    logic                    timeout_n;

    // Hold counter: cleared on each new grant, saturates at MAX_HOLD.
    always_comb begin
        hold_cnt_n = hold_cnt;
        if (state == IDLE) begin
            hold_cnt_n = '0;
        end else if (|bus_lv1_lv2_gnt_proc) begin
            if (hold_cnt != HOLD_CNT_WID'(MAX_HOLD)) hold_cnt_n = hold_cnt + HOLD_CNT_WID'(1);
        end
        timeout_n = arb_timeout | (hold_cnt_n == HOLD_CNT_WID'(MAX_HOLD));
    end

    // Sticky timeout flag; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt    <= '0;
            arb_timeout <= 1'b0;
        end else begin
            hold_cnt    <= hold_cnt_n;
            arb_timeout <= timeout_n;
        end
    end
`else
    assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lv1_lv2_bus_arbiter.sv
// Directed vector bench for lv1_lv2_bus_arbiter.
module tb_lv1_lv2_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_proc  = '0;
    logic [3:0] req_snoop = '0;
    logic [3:0] gnt_proc, gnt_snoop;
    logic [1:0] gnt_proc_id;
    logic       bus_busy, arb_timeout;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       rst;
        logic [3:0] rp;
        logic [3:0] rs;
        logic [3:0] gp;
        logic [3:0] gs;
        logic [1:0] id;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    lv1_lv2_bus_arbiter #(
        .NUM_CORES(4), .CORE_ID_WID(2), .HOLD_CNT_WID(8), .MAX_HOLD(8)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .bus_lv1_lv2_req_proc  (req_proc),
        .bus_lv1_lv2_req_snoop (req_snoop),
        .bus_lv1_lv2_gnt_proc  (gnt_proc),
        .bus_lv1_lv2_gnt_snoop (gnt_snoop),
        .gnt_proc_id           (gnt_proc_id),
        .bus_busy              (bus_busy),
        .arb_timeout           (arb_timeout)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] rp, input logic [3:0] rs,
                       input logic [3:0] gp, input logic [3:0] gs, input logic [1:0] id,
                       input logic busy);
        vec_t v;
        v.rst = r; v.rp = rp; v.rs = rs; v.gp = gp; v.gs = gs; v.id = id; v.busy = busy;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] gp, input logic [3:0] gs,
                         input logic [1:0] id, input logic busy, input logic to);
        n_vec++;
        if (gnt_proc !== gp || gnt_snoop !== gs || gnt_proc_id !== id ||
            bus_busy !== busy || arb_timeout !== to) begin
            n_err++;
            $display("FAIL %s: got gp=%b gs=%b id=%0d busy=%b to=%b, want gp=%b gs=%b id=%0d busy=%b to=%b",
                     name, gnt_proc, gnt_snoop, gnt_proc_id, bus_busy, arb_timeout,
                     gp, gs, id, busy, to);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rp, input logic [3:0] rs);
        @(negedge clk);
        rst       = r;
        req_proc  = rp;
        req_snoop = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst rp rs | gp gs id busy   (outputs after the edge that samples the inputs)
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0); // reset
        add(0, 4'b1010, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1); // first grant core1
        add(0, 4'b1010, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1); // held
        add(0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0); // core1 drops, turnaround
        add(0, 4'b1010, 4'b0000, 4'b1000, 4'b0000, 2'd3, 1); // core3 wins from ptr 2
        add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'd3, 0); // core3 drops
        add(0, 4'b1010, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1); // wrap -> core1
        add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0); // id held in IDLE
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0); // reset
        add(0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1); // owner core0
        add(0, 4'b0001, 4'b0111, 4'b0001, 4'b0010, 2'd0, 1); // own snoop bit masked
        add(0, 4'b0001, 4'b0111, 4'b0001, 4'b0010, 2'd0, 1); // both held
        add(0, 4'b0001, 4'b0101, 4'b0001, 4'b0000, 2'd0, 1); // snooper drops
        add(0, 4'b0001, 4'b0101, 4'b0001, 4'b0100, 2'd0, 1); // next snooper core2
        add(0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 2'd0, 1); // core2 drops -> PROC
        add(0, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 2'd0, 0); // owner drop beats snoop
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0); // reset
        add(0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1); // owner core2
        add(0, 4'b0100, 4'b1100, 4'b0100, 4'b1000, 2'd2, 1); // snoop core3
        add(0, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 2'd2, 1); // owner drops -> drain
        add(0, 4'b0001, 4'b1000, 4'b0000, 4'b1000, 2'd2, 1); // proc req waits
        add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0); // drain done -> IDLE
        add(0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1); // core0 from ptr 3 (wrap)
        add(0, 4'b0001, 4'b0110, 4'b0001, 4'b0010, 2'd0, 1); // snoop core1
        add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0); // both drop -> IDLE
        add(0, 4'b1111, 4'b1111, 4'b0010, 4'b0000, 2'd1, 1); // ptr 1; snoop ignored in IDLE
        add(0, 4'b1111, 4'b1111, 4'b0010, 4'b0100, 2'd1, 1); // snoop ptr 2 -> core2

        rst = 1'b1;
        #2;
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].rp, vecs[i].rs);
            check($sformatf("vec%0d", i), vecs[i].gp, vecs[i].gs, vecs[i].id, vecs[i].busy, 1'b0);
        end

        // Async reset mid-cycle while in PROC_SNOOP clears grants before any edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1, 4'b0000, 4'b0000);
        step(0, 4'b1111, 4'b0000);
        check("post_rst_lowest", 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0);

`ifdef LV1_LV2_ARB_TIMEOUT_EN
        // Hold core0 for 12 cycles; flag rises after 8 granted cycles and is sticky.
        step(1, 4'b0000, 4'b0000);
        step(0, 4'b0001, 4'b0000);
        check("to_grant", 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            step(0, 4'b0001, 4'b0000);
            check($sformatf("to_hold%0d", k), 4'b0001, 4'b0000, 2'd0, 1'b1, (k >= 8));
        end
        step(0, 4'b0000, 4'b0000);
        check("to_release", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);
        step(0, 4'b0000, 4'b0000);
        check("to_sticky", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);
        step(1, 4'b0000, 4'b0000);
        check("to_rst_clear", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
`else
        // Without the feature the flag stays low even on a long hold.
        for (int k = 1; k <= 12; k++) step(0, 4'b0001, 4'b0000);
        check("to_off", 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
